// File: rtl/trace_commit_arbiter.sv
// rtl/trace_commit_arbiter.sv - dual-port commit capture FIFO serialized onto one trace stream
// Records carry a 16-bit sequence number; commits that find no room are counted as drops.
module trace_commit_arbiter #(
  parameter int DEPTH = 8,
  parameter int VLEN  = 64,
  parameter int XLEN  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [1:0]               commit_valid_i,
  input  logic [2*VLEN-1:0]        commit_pc_i,
  input  logic [63:0]              commit_instr_i,
  input  logic [9:0]               commit_rd_i,
  input  logic [1:0]               commit_we_i,
  input  logic [2*XLEN-1:0]        commit_wdata_i,
  input  logic                     flush_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [VLEN-1:0]          trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic [4:0]               trace_rd_o,
  output logic                     trace_we_o,
  output logic [XLEN-1:0]          trace_wdata_o,
  output logic                     trace_port_o,
  output logic [15:0]              trace_seq_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [31:0]              drop_cnt_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic            port;
    logic [15:0]     seq;
  } rec_t;

  rec_t          mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, base, w1_addr;
  logic [FW-1:0] fill_q, fill_d, free;
  logic [15:0]   seq_q, seq_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  logic [32:0]   drop_sum;
  logic          overflow_q, overflow_d;
  logic          transfer, acc0, acc1;
  logic [1:0]    cv, n, n_acc, n_drop;
  rec_t          rec0, rec1, head;

  always_comb begin
    transfer = (fill_q != '0) && trace_ready_i;
    // A flush empties everything except a head leaving this cycle, so the whole FIFO is open.
    free     = flush_i ? FW'(DEPTH) : FW'(DEPTH) - fill_q + FW'(transfer);
    cv       = enable_i ? commit_valid_i : 2'b00;
    acc0     = cv[0] && (free != '0);
    acc1     = cv[1] && (cv[0] ? (free >= FW'(2)) : (free != '0));
    n        = {1'b0, cv[0]} + {1'b0, cv[1]};
    n_acc    = {1'b0, acc0} + {1'b0, acc1};
    n_drop   = n - n_acc;

    rd_ptr_d = rd_ptr_q + AW'(transfer);
    base     = flush_i ? rd_ptr_d : wr_ptr_q;
    w1_addr  = base + AW'(acc0);
    wr_ptr_d = base + AW'(n_acc);
    fill_d   = (flush_i ? '0 : fill_q - FW'(transfer)) + FW'(n_acc);
    seq_d    = seq_q + {14'd0, n};

    drop_sum   = {1'b0, drop_cnt_q} + {31'd0, n_drop};
    drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
    overflow_d = overflow_q | (n_drop != 2'd0);

    rec0.pc    = commit_pc_i[VLEN-1:0];
    rec0.instr = commit_instr_i[31:0];
    rec0.rd    = commit_rd_i[4:0];
    rec0.we    = commit_we_i[0];
    rec0.wdata = commit_wdata_i[XLEN-1:0];
    rec0.port  = 1'b0;
    rec0.seq   = seq_q;

    rec1.pc    = commit_pc_i[VLEN +: VLEN];
    rec1.instr = commit_instr_i[32 +: 32];
    rec1.rd    = commit_rd_i[5 +: 5];
    rec1.we    = commit_we_i[1];
    rec1.wdata = commit_wdata_i[XLEN +: XLEN];
    rec1.port  = 1'b1;
    rec1.seq   = seq_q + {15'd0, cv[0]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc0) mem_q[base] <= rec0;
    if (acc1) mem_q[w1_addr] <= rec1;
  end

  // Storage is not reset, so the payload is masked while the FIFO is empty.
  assign head          = mem_q[rd_ptr_q];
  assign trace_valid_o = (fill_q != '0);
  assign trace_pc_o    = trace_valid_o ? head.pc    : '0;
  assign trace_instr_o = trace_valid_o ? head.instr : '0;
  assign trace_rd_o    = trace_valid_o ? head.rd    : '0;
  assign trace_we_o    = trace_valid_o & head.we;
  assign trace_wdata_o = trace_valid_o ? head.wdata : '0;
  assign trace_port_o  = trace_valid_o & head.port;
  assign trace_seq_o   = trace_valid_o ? head.seq   : '0;
  assign fill_o        = fill_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_trace_commit_arbiter.sv
// tb/tb_trace_commit_arbiter.sv - scoreboard bench for trace_commit_arbiter
// Stimulus updates a queue-based reference; a negedge monitor pops it on every transfer.
module tb_trace_commit_arbiter;
  localparam int DEPTH = 8;
  localparam int VLEN  = 64;
  localparam int XLEN  = 64;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              enable_i = 1'b0;
  logic [1:0]        commit_valid_i = '0;
  logic [2*VLEN-1:0] commit_pc_i = '0;
  logic [63:0]       commit_instr_i = '0;
  logic [9:0]        commit_rd_i = '0;
  logic [1:0]        commit_we_i = '0;
  logic [2*XLEN-1:0] commit_wdata_i = '0;
  logic              flush_i = 1'b0;
  logic              trace_valid_o;
  logic              trace_ready_i = 1'b0;
  logic [VLEN-1:0]   trace_pc_o;
  logic [31:0]       trace_instr_o;
  logic [4:0]        trace_rd_o;
  logic              trace_we_o;
  logic [XLEN-1:0]   trace_wdata_o;
  logic              trace_port_o;
  logic [15:0]       trace_seq_o;
  logic [3:0]        fill_o;
  logic [31:0]       drop_cnt_o;
  logic              overflow_o;

  trace_commit_arbiter #(.DEPTH(DEPTH), .VLEN(VLEN), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .commit_rd_i(commit_rd_i),
    .commit_we_i(commit_we_i), .commit_wdata_i(commit_wdata_i),
    .flush_i(flush_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o), .trace_rd_o(trace_rd_o),
    .trace_we_o(trace_we_o), .trace_wdata_o(trace_wdata_o), .trace_port_o(trace_port_o),
    .trace_seq_o(trace_seq_o), .fill_o(fill_o), .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] wdata;
    logic        port;
    logic [15:0] seq;
  } rec_t;

  rec_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_seq = '0;
  logic [31:0] m_drop = '0;
  logic        m_ovf = 1'b0;
  int          m_fill = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rec_t got, e;
    if (rst_ni && trace_valid_o && trace_ready_i) begin
      got = {trace_pc_o, trace_instr_o, trace_rd_o, trace_we_o, trace_wdata_o, trace_port_o, trace_seq_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL trace_unexpected: got pc=%h seq=%h want no record", got.pc, got.seq);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL trace_record: got pc=%h seq=%h port=%b instr=%h want pc=%h seq=%h port=%b instr=%h",
                   got.pc, got.seq, got.port, got.instr, e.pc, e.seq, e.port, e.instr);
        end
      end
    end
  end

  // Reference: the head stays queued until the monitor sees it leave, new records go behind it.
  task automatic model_apply();
    int  sz, free;
    bit  xfer;
    rec_t r;
    sz   = exp_q.size();
    xfer = (sz > 0) && trace_ready_i;
    if (flush_i) begin
      while (exp_q.size() > (xfer ? 1 : 0)) void'(exp_q.pop_back());
      free = DEPTH;
    end else begin
      free = DEPTH - sz + (xfer ? 1 : 0);
    end
    if (enable_i) begin
      for (int p = 0; p < 2; p++) begin
        if (commit_valid_i[p]) begin
          r.pc    = commit_pc_i[p*64 +: 64];
          r.instr = commit_instr_i[p*32 +: 32];
          r.rd    = commit_rd_i[p*5 +: 5];
          r.we    = commit_we_i[p];
          r.wdata = commit_wdata_i[p*64 +: 64];
          r.port  = p[0];
          r.seq   = m_seq;
          m_seq   = m_seq + 16'd1;
          if (free > 0) begin
            exp_q.push_back(r);
            free--;
          end else begin
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            m_ovf = 1'b1;
          end
        end
      end
    end
    m_fill = exp_q.size() - (xfer ? 1 : 0);
  endtask

  task automatic step(input bit en, input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                      input bit fl, input bit rdy);
    enable_i       = en;
    commit_valid_i = v;
    commit_pc_i    = {pc1, pc0};
    commit_instr_i = {$urandom, $urandom};
    commit_rd_i    = 10'($urandom);
    commit_we_i    = 2'($urandom);
    commit_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    flush_i        = fl;
    trace_ready_i  = rdy;
    model_apply();
    @(posedge clk); #1;
    chk("fill", 64'(fill_o), 64'(m_fill));
    chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("valid", 64'(trace_valid_o), 64'(m_fill != 0));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; enable_i = 1'b0; commit_valid_i = '0; flush_i = 1'b0; trace_ready_i = 1'b1;
    exp_q.delete();
    m_seq = '0; m_drop = '0; m_ovf = 1'b0; m_fill = 0;
    @(posedge clk); #1;
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_fill", 64'(fill_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_pc", trace_pc_o, 64'd0);
    chk("rst_seq", 64'(trace_seq_o), 64'd0);
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4*DEPTH && exp_q.size() != 0; i++) step(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    do_reset();

    step(1'b1, 2'b01, 64'h8000_0000, 64'd0, 1'b0, 1'b1);
    chk("single_pc", trace_pc_o, 64'h8000_0000);
    chk("single_seq", 64'(trace_seq_o), 64'd0);
    step(1'b1, 2'b01, 64'h8000_0004, 64'd0, 1'b0, 1'b1);
    chk("single_seq1", 64'(trace_seq_o), 64'd1);
    step(1'b1, 2'b01, 64'h8000_0008, 64'd0, 1'b0, 1'b1);
    drain();

    do_reset();
    step(1'b1, 2'b11, 64'h8000_0000, 64'h8000_0004, 1'b0, 1'b1);
    chk("dual_head_port", 64'(trace_port_o), 64'd0);
    step(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("dual_second_pc", trace_pc_o, 64'h8000_0004);
    chk("dual_second_port", 64'(trace_port_o), 64'd1);
    drain();

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 64'h100 + 64'(8*i), 64'h104 + 64'(8*i), 1'b0, 1'b0);
    chk("full_fill", 64'(fill_o), 64'd8);
    step(1'b1, 2'b11, 64'h200, 64'h204, 1'b0, 1'b0);
    chk("full_drop", 64'(drop_cnt_o), 64'd2);
    chk("full_ovf", 64'(overflow_o), 64'd1);
    drain();
    step(1'b1, 2'b01, 64'h300, 64'd0, 1'b0, 1'b0);
    chk("after_drop_seq", 64'(trace_seq_o), 64'd10);
    drain();

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 64'h400 + 64'(8*i), 64'h404 + 64'(8*i), 1'b0, 1'b0);
    step(1'b1, 2'b11, 64'h500, 64'h504, 1'b0, 1'b1);
    chk("full_xfer_fill", 64'(fill_o), 64'd8);
    chk("full_xfer_drop", 64'(drop_cnt_o), 64'd1);
    drain();

    do_reset();
    step(1'b1, 2'b11, 64'h600, 64'h604, 1'b0, 1'b0);
    step(1'b1, 2'b11, 64'h608, 64'h60C, 1'b0, 1'b0);
    step(1'b1, 2'b01, 64'h700, 64'd0, 1'b1, 1'b0);
    chk("flush_fill", 64'(fill_o), 64'd1);
    chk("flush_seq", 64'(trace_seq_o), 64'd4);
    chk("flush_drop", 64'(drop_cnt_o), 64'd0);
    drain();

    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 9) != 0), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
    drain();

    do_reset();
    for (int i = 0; i < 32767; i++) step(1'b1, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
    drain();
    step(1'b1, 2'b11, 64'hA000, 64'hA004, 1'b0, 1'b0);
    chk("wrap_seq_fffe", 64'(trace_seq_o), 64'hFFFE);
    step(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("wrap_seq_ffff", 64'(trace_seq_o), 64'hFFFF);
    step(1'b1, 2'b01, 64'hA008, 64'd0, 1'b0, 1'b1);
    chk("wrap_seq_0000", 64'(trace_seq_o), 64'h0000);
    step(1'b1, 2'b11, 64'hB000, 64'hB004, 1'b0, 1'b0);
    step(1'b1, 2'b11, 64'hB008, 64'hB00C, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trace_commit_arbiter.md
Name: trace_commit_arbiter

Overview:
- Synthesizable front end for commit tracing on the dual-commit core.
- Captures up to two retiring instructions per cycle from commit ports 0 and 1.
- Buffers them in a small FIFO and serializes them, in program order, onto a single valid/ready trace stream. That stream is shared by the trace sink (file writer, DPI, or on-chip trace buffer).
- Tags every record with a sequence number and counts records it had to drop, so the sink can detect gaps.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >=2.
- VLEN, 64, PC width.
- XLEN, 64, write-back data width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- enable_i  in  1  capture enable; when 0, commits are ignored
- commit_valid_i  in  2  per-port commit acknowledge; bit0 = older instruction
- commit_pc_i  in  2*VLEN  PCs; port i at [i*VLEN +: VLEN]
- commit_instr_i  in  64  instruction words; port i at [i*32 +: 32]
- commit_rd_i  in  10  destination registers; port i at [i*5 +: 5]
- commit_we_i  in  2  register write enable per port
- commit_wdata_i  in  2*XLEN  write-back data per port
- flush_i  in  1  discard buffered, not-yet-transferred records
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  sink accepts head record
- trace_pc_o  out  VLEN  head PC
- trace_instr_o  out  32  head instruction
- trace_rd_o  out  5  head rd
- trace_we_o  out  1  head write enable
- trace_wdata_o  out  XLEN  head write data
- trace_port_o  out  1  commit port the head came from
- trace_seq_o  out  16  head sequence number
- fill_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_cnt_o  out  32  dropped-record counter
- overflow_o  out  1  sticky; set on first drop

Behaviour:
- Reset (rst_ni=0 at a clock edge): FIFO emptied, sequence counter=0, drop_cnt_o=0, overflow_o=0. All outputs read 0 the following cycle. A reset mid-stream discards all pending records with no drop count.
- Transfer: occurs when trace_valid_o && trace_ready_i. trace_valid_o = (fill!=0). Payload is the FIFO head, driven from registers, and holds stable while valid && !ready.
- Latency: a record committed in cycle t is visible at the earliest in cycle t+1.
- Capture, only when enable_i=1:
  - n = popcount(commit_valid_i).
  - free = DEPTH - fill + (transfer this cycle ? 1 : 0).
- Ordering: port 0 is enqueued before port 1. commit_valid_i=2'b10 enqueues port 1 alone.
- Admission:
  - n<=free: enqueue all.
  - n=2, free=1: enqueue port 0, drop port 1.
  - free=0: drop all.
- Sequence numbers:
  - Each valid commit, accepted or dropped, consumes one sequence number in port order; the counter advances by n.
  - 16-bit, wraps 0xFFFF->0x0000.
  - trace_seq_o carries the stored number.
- Drop accounting: drop_cnt_o += dropped count, saturating at 0xFFFFFFFF. overflow_o set on any drop and cleared only by reset.
- Disabled (enable_i=0): commits are ignored entirely (no enqueue, no seq advance, no drop count). Buffered records continue to drain.
- flush_i=1:
  - All entries not transferred this cycle are discarded and are not counted as drops.
  - A head transfer in the same cycle completes normally.
  - Same-cycle commits are enqueued into the emptied FIFO, with free=DEPTH.
  - The sequence counter is not reset.
- fill_o next = (flush ? 0 : fill - pop) + accepted.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by the fill counter.
- No combinational path from commit_* inputs to trace_* outputs. trace_ready_i may combinationally affect admission, via free.

Test Plan:
- Single port-0 commits, PC 0x80000000, 0x80000004, 0x80000008, ready=1 -> records appear one cycle later with seq 0, 1, 2, port 0, fill never exceeds 1.
- Dual commit, valid=2'b11, PC 0x80000000 (p0) / 0x80000004 (p1), ready=1 -> output 0x80000000 seq 0 port 0, then 0x80000004 seq 1 port 1 on consecutive cycles.
- DEPTH=8, ready=0, five consecutive dual commits -> fill=8 after four; fifth cycle drops both (seq 8, 9); drop_cnt=2; overflow=1. Then ready=1 drains seq 0..7, and the next commit carries seq 10.
- FIFO full, ready=1, dual commit in same cycle -> head transferred, port 0 accepted, port 1 dropped, fill stays 8, drop_cnt+1.
- 4 records pending, flush_i=1 with simultaneous port-0 commit and ready=0 -> next cycle fill=1; the only output is the new record, with seq continuing from the counter; drop_cnt unchanged.
- Seq counter at 0xFFFE, dual commit -> seq 0xFFFE, 0xFFFF. Next commit is seq 0x0000. Assert rst_ni=0 mid-drain -> next cycle trace_valid_o=0, fill=0, drop_cnt=0, overflow=0.
